// File: rtl/cache_assoc.sv
// Parametrised set-associative, write-through, write-allocate cache with pipelined refill.
// Optional hit/miss counters: define CACHE_ASSOC_STATS_EN.
module cache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_busy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_res_rdata,
`ifdef CACHE_ASSOC_STATS_EN
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt,
`endif
  output logic [1:0]  o_dbg_state
);
  localparam int WOFF = $clog2(LINE_WORDS);
  localparam int OFF  = WOFF + 2;
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = 32 - OFF - IDX;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW   = WOFF + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;
  state_t state_q, state_d;

  logic [31:0]    data_q  [WAYS][SETS][LINE_WORDS];
  logic [TAG-1:0] tag_q   [WAYS][SETS];
  logic           valid_q [WAYS][SETS];
  logic [WW-1:0]  ptr_q   [SETS];

  logic [CW-1:0]   issue_q;
  logic [WOFF-1:0] recv_q;
  logic [WW-1:0]   vic_q;
  logic            is_write_q;
  logic            ren_q;
  logic [31:0]     rd_addr_q;

  logic [TAG-1:0]  req_tag;
  logic [IDX-1:0]  req_idx;
  logic [WOFF-1:0] req_word;
  logic [31:0]     line_base;
  assign req_tag   = i_req_addr[31:OFF+IDX];
  assign req_idx   = i_req_addr[OFF+IDX-1:OFF];
  assign req_word  = i_req_addr[OFF-1:2];
  assign line_base = {i_req_addr[31:OFF], {OFF{1'b0}}};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] m);
    merge_bytes = old_w;
    for (int b = 0; b < 4; b++)
      if (m[b]) merge_bytes[b*8 +: 8] = new_w[b*8 +: 8];
  endfunction

  logic          hit, inv_found;
  logic [WW-1:0] hit_way, inv_way, victim, ptr_next;
  logic [31:0]   hit_word, mask32, fill_old;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[w][req_idx] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  assign hit_word    = data_q[hit_way][req_idx][req_word];
  assign mask32      = {{8{i_req_mask[3]}}, {8{i_req_mask[2]}}, {8{i_req_mask[1]}}, {8{i_req_mask[0]}}};
  assign o_res_rdata = hit ? (hit_word & mask32) : 32'h0;
  assign victim      = inv_found ? inv_way : ptr_q[req_idx];
  assign ptr_next    = (ptr_q[req_idx] == WW'(WAYS - 1)) ? '0 : ptr_q[req_idx] + 1'b1;
  // The last refill word may be the one being written, so merge against the incoming data.
  assign fill_old    = (req_word == WOFF'(LINE_WORDS - 1)) ? i_mem_rdata
                                                           : data_q[vic_q][req_idx][req_word];

  assign o_mem_ren   = ren_q;
  assign o_mem_addr  = (state_q == S_WRITE) ? i_req_addr : rd_addr_q;
  assign o_mem_wdata = (state_q == S_WRITE) ? hit_word : 32'h0;
  assign o_dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    o_busy    = 1'b0;
    o_mem_wen = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((i_req_ren || i_req_wen) && !hit) begin
          o_busy  = 1'b1;
          state_d = S_FILL;
        end else if (i_req_wen) begin
          o_busy  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_FILL: begin
        o_busy = 1'b1;
        if (i_mem_valid && recv_q == WOFF'(LINE_WORDS - 1))
          state_d = is_write_q ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        o_mem_wen = 1'b1;
        o_busy    = !i_mem_ready;
        if (i_mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      ren_q      <= 1'b0;
      rd_addr_q  <= '0;
      issue_q    <= '0;
      recv_q     <= '0;
      vic_q      <= '0;
      is_write_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      ren_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if ((i_req_ren || i_req_wen) && !hit) begin
            vic_q                   <= victim;
            valid_q[victim][req_idx] <= 1'b0;
            is_write_q              <= i_req_wen;
            issue_q                 <= '0;
            recv_q                  <= '0;
          end else if (i_req_wen) begin
            data_q[hit_way][req_idx][req_word] <= merge_bytes(hit_word, i_req_wdata, i_req_mask);
          end
        end
        S_FILL: begin
          if (issue_q < CW'(LINE_WORDS) && i_mem_ready) begin
            ren_q     <= 1'b1;
            rd_addr_q <= line_base | (32'(issue_q) << 2);
            issue_q   <= issue_q + 1'b1;
          end
          if (i_mem_valid) begin
            data_q[vic_q][req_idx][recv_q] <= i_mem_rdata;
            tag_q[vic_q][req_idx]          <= req_tag;
            recv_q                         <= recv_q + 1'b1;
            if (recv_q == WOFF'(LINE_WORDS - 1)) begin
              valid_q[vic_q][req_idx] <= 1'b1;
              if (vic_q == ptr_q[req_idx]) ptr_q[req_idx] <= ptr_next;
              if (is_write_q)
                data_q[vic_q][req_idx][req_word] <= merge_bytes(fill_old, i_req_wdata, i_req_mask);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_ASSOC_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (state_q == S_IDLE && (i_req_ren || i_req_wen)) begin
      if (hit) begin
        if (o_hit_cnt != 32'hFFFF_FFFF) o_hit_cnt <= o_hit_cnt + 1'b1;
      end else begin
        if (o_miss_cnt != 32'hFFFF_FFFF) o_miss_cnt <= o_miss_cnt + 1'b1;
      end
    end
  end
`endif
endmodule
